// File: rtl/tb_uart_hex_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_hex_rx
//  Brief    : Bench-side UART receiver for the hex-dump transmitter.
//             Deserialises 8N1 bytes (LSB first, idle high) and parses
//             "XXXXXXXX\r\n" lines into 32-bit words, flagging bad lines.
//  Options  : TB_UART_HEX_RX_SHORTLINE_EN - accept lines of 1..8 digits,
//             right-aligned and zero-extended into value.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_hex_rx #(
    parameter int BAUDRATE    = 115200,
    parameter int MASTERCLOCK = 50000000,
    parameter int SAMPLECLOCK = MASTERCLOCK / BAUDRATE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    output logic [31:0] value,
    output logic        value_good,
    output logic        error
);

    // Byte FSM encoding
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    // A bit lasts SAMPLECLOCK+1 cycles; the start bit is checked half a bit in
    localparam logic [8:0] c_bit_reload  = 9'(SAMPLECLOCK);
    localparam logic [8:0] c_half_reload = 9'((SAMPLECLOCK + 1) / 2);

    localparam logic [7:0] c_ascii_cr = 8'h0D;
    localparam logic [7:0] c_ascii_lf = 8'h0A;

    logic        r_rx_meta;
    logic        r_rxs;
    logic [1:0]  r_state;
    logic        r_armed;
    logic [8:0]  r_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [31:0] r_acc;
    logic [3:0]  r_digits;
    logic        r_line_bad;

    logic        w_cnt_zero;
    logic        w_byte_valid;
    logic        w_frame_err;
    logic [4:0]  w_hex;
    logic        w_line_ok;

    // Maps an ASCII hex character to {valid, nibble}
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [7:0] d;
        if (b >= 8'h30 && b <= 8'h39) begin
            d = b - 8'h30;
            return {1'b1, d[3:0]};
        end else if (b >= 8'h41 && b <= 8'h46) begin
            d = b - 8'h37;
            return {1'b1, d[3:0]};
        end else if (b >= 8'h61 && b <= 8'h66) begin
            d = b - 8'h57;
            return {1'b1, d[3:0]};
        end
        return 5'd0;
    endfunction

    assign w_cnt_zero   = (r_cnt == 9'd0);
    // The two STOP outcomes are exclusive by construction: rxs is either 1 or 0
    assign w_byte_valid = (r_state == c_stop) && w_cnt_zero && r_rxs;
    assign w_frame_err  = (r_state == c_stop) && w_cnt_zero && !r_rxs;
    assign w_hex        = hex_decode(r_shift);

`ifdef TB_UART_HEX_RX_SHORTLINE_EN
    // Any non-empty line of at most 8 clean digits is a word
    assign w_line_ok = !r_line_bad && (r_digits != 4'd0);
`else
    // Only a full 8-digit clean line is a word
    assign w_line_ok = !r_line_bad && (r_digits == 4'd8);
`endif

    // Two-flop synchroniser on the serial input, idling high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // Byte deserialiser: start detect, mid-bit sampling, stop-bit check
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_idle;
            r_armed   <= 1'b0;
            r_cnt     <= 9'd0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    // Re-arm only on a high line so a held break is one event
                    if (r_rxs) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= c_start;
                        r_cnt   <= c_half_reload;
                    end
                end
                c_start: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 9'd1;
                    end else if (!r_rxs) begin
                        r_state   <= c_data;
                        r_cnt     <= c_bit_reload;
                        r_bit_cnt <= 3'd0;
                    end else begin
                        // Too short to be a start bit: treat as noise
                        r_state <= c_idle;
                        r_armed <= 1'b0;
                    end
                end
                c_data: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 9'd1;
                    end else begin
                        r_shift <= {r_rxs, r_shift[7:1]};
                        r_cnt   <= c_bit_reload;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_stop;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 9'd1;
                    end else begin
                        r_state <= c_idle;
                        r_armed <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Line parser: accumulate hex digits, judge the line on LF
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc      <= 32'd0;
            r_digits   <= 4'd0;
            r_line_bad <= 1'b0;
            value      <= 32'd0;
            value_good <= 1'b0;
            error      <= 1'b0;
        end else begin
            value_good <= 1'b0;
            error      <= 1'b0;
            if (w_frame_err) begin
                r_line_bad <= 1'b1;
            end else if (w_byte_valid) begin
                if (r_shift == c_ascii_lf) begin
                    if (w_line_ok) begin
                        value      <= r_acc;
                        value_good <= 1'b1;
                    end else begin
                        error <= 1'b1;
                    end
                    r_acc      <= 32'd0;
                    r_digits   <= 4'd0;
                    r_line_bad <= 1'b0;
                end else if (r_shift == c_ascii_cr) begin
                    r_line_bad <= r_line_bad;
                end else if (w_hex[4]) begin
                    if (r_digits < 4'd8) begin
                        r_acc    <= {r_acc[27:0], w_hex[3:0]};
                        r_digits <= r_digits + 4'd1;
                    end else begin
                        r_line_bad <= 1'b1;
                    end
                end else begin
                    r_line_bad <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
